// File: rtl/pkt_rx_checker.sv
// -----------------------------------------------------------------------------
// pkt_rx_checker
//
// Receives a packet stream from one SRAM controller read port and checks it.
// A beat is accepted ("fires") when in_valid & in_ready. Every packet must
// start with sop and end with eop. Its payload must be an incrementing byte
// pattern: the beat at index i carries i mod 2^DATA_W, with index 0 at sop.
// The block reports packet, error and length status for benches and BIST.
//
// Parameters
//   DATA_W  : payload width
//   MAX_LEN : maximum legal beats per packet (sop and eop inclusive), >= 1
//   CNT_W   : width of the saturating status counters
//
// Ports
//   clock      in   single clock, rising edge
//   reset      in   synchronous, active-low (0 resets the block)
//   enable     in   1 allows acceptance, 0 forces in_ready low
//   clear      in   synchronous clear of counters, err_code and last_len
//   in_valid   in   beat valid
//   in_data    in   beat payload [DATA_W]
//   in_sop     in   first beat of packet
//   in_eop     in   last beat of packet
//   in_ready   out  beat accepted this cycle if in_valid is high
//   pkt_count  out  packets closed by an accepted eop [CNT_W], saturating
//   good_count out  error-free packets [CNT_W], saturating
//   err_count  out  error events [CNT_W], saturating
//   err_code   out  sticky flags: 0 orphan beat, 1 sop inside packet,
//                   2 data mismatch, 3 over-length
//   last_len   out  beat count of the most recent packet closed by eop
//   busy       out  FSM not in IDLE
//   dbg_state  out  raw FSM state (0 IDLE, 1 IN_PKT, 2 DROP)
//
// Handshake: in_ready depends only on registered state, enable and reset.
// It never depends on in_valid. When in_valid is high, the sender must hold
// in_data/in_sop/in_eop stable until the cycle in which in_ready is high.
// The beat is consumed on that rising edge.
//
// Optional build macro: PKT_RX_BACKPRESSURE_EN
//   When defined, a 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1, seed
//   0xACE1) advances every cycle. Its bit 0 also gates in_ready, so the
//   sender stalls on roughly half the cycles.
// -----------------------------------------------------------------------------
module pkt_rx_checker #(
  parameter int DATA_W  = 8,
  parameter int MAX_LEN = 64,
  parameter int CNT_W   = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] in_data,
  input  logic              in_sop,
  input  logic              in_eop,
  output logic              in_ready,
  output logic [CNT_W-1:0]  pkt_count,
  output logic [CNT_W-1:0]  good_count,
  output logic [CNT_W-1:0]  err_count,
  output logic [3:0]        err_code,
  output logic [15:0]       last_len,
  output logic              busy,
  output logic [1:0]        dbg_state
);

  // The index must be wide enough for both the 16-bit length report and the
  // payload comparison.
  localparam int IDX_W = (DATA_W > 16) ? DATA_W : 16;
  localparam logic [IDX_W-1:0] MAX_LEN_V = IDX_W'(MAX_LEN);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_IN_PKT = 2'd1,
    S_DROP   = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IDX_W-1:0] r_idx;        // index expected on the next in-packet beat
  logic             r_bad;        // current packet has seen an error
  logic [15:0]      r_drop;       // beats discarded so far in DROP

  logic             w_fire;
  logic             w_start;      // sop beat: always begins a new packet
  logic             w_restart;    // sop beat while a packet was open
  logic             w_orphan;     // non-sop beat while idle
  logic             w_data_beat;  // beat that belongs to a checked packet
  logic [IDX_W-1:0] w_base;       // index of the current beat
  logic [IDX_W-1:0] w_idx_nxt;
  logic             w_mismatch;
  logic             w_over;
  logic             w_bad_nxt;
  logic             w_close_pkt;
  logic             w_close_drop;
  logic             w_err_evt;
  logic [17:0]      w_drop_sum;
  logic [15:0]      w_drop_len;

`ifdef PKT_RX_BACKPRESSURE_EN
  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  // Taps 16,14,13,11 map to bits 15,13,12,10 of a left-shifting register.
  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clock) begin
    if (!reset) begin
      r_lfsr <= 16'hACE1;
    end else begin
      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
    end
  end
`endif

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  // ---------------------------------------------------------------------------
  // Beat decode
  // ---------------------------------------------------------------------------
  always_comb begin
    w_fire       = in_valid & in_ready;
    w_start      = w_fire & in_sop;
    w_restart    = w_start & (r_state != S_IDLE);
    w_orphan     = w_fire & ~in_sop & (r_state == S_IDLE);
    w_data_beat  = w_start | (w_fire & (r_state == S_IN_PKT));
    // A sop beat always counts as index 0, even when it interrupts a packet.
    w_base       = w_start ? '0 : r_idx;
    w_idx_nxt    = w_base + 1'b1;
    w_mismatch   = w_data_beat & (in_data != w_base[DATA_W-1:0]);
    // Reaching MAX_LEN is legal only if that beat carries eop. The >= test
    // also covers MAX_LEN == 1 on a lone sop beat.
    w_over       = w_data_beat & ~in_eop & (w_idx_nxt >= MAX_LEN_V);
    // A restart clears the bad mark. The abandoned packet is never counted.
    w_bad_nxt    = (w_start ? 1'b0 : r_bad) | w_mismatch | w_over;
    w_close_pkt  = w_data_beat & in_eop;
    w_close_drop = w_fire & ~in_sop & in_eop & (r_state == S_DROP);
    // Several errors on one beat count as one event.
    w_err_evt    = w_orphan | w_restart | w_mismatch | w_over;
    // In DROP the reported length is MAX_LEN plus every discarded beat,
    // including the closing eop beat. It saturates at 16 bits.
    w_drop_sum   = 18'(MAX_LEN) + {2'b00, r_drop} + 18'd1;
    w_drop_len   = (w_drop_sum > 18'h0FFFF) ? 16'hFFFF : w_drop_sum[15:0];
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_nxt = r_state;
    if (w_data_beat) begin
      if (in_eop) begin
        w_state_nxt = S_IDLE;
      end else if (w_over) begin
        w_state_nxt = S_DROP;
      end else begin
        w_state_nxt = S_IN_PKT;
      end
    end else if (w_close_drop) begin
      w_state_nxt = S_IDLE;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    busy      = (r_state != S_IDLE);
    dbg_state = r_state;
`ifdef PKT_RX_BACKPRESSURE_EN
    in_ready  = enable & reset & r_lfsr[0];
`else
    in_ready  = enable & reset;
`endif
  end

  // ---------------------------------------------------------------------------
  // Packet tracking. The clear input does not affect these registers.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset) begin
      r_idx  <= '0;
      r_bad  <= 1'b0;
      r_drop <= '0;
    end else if (w_data_beat) begin
      r_idx  <= w_idx_nxt;
      r_bad  <= w_bad_nxt;
      r_drop <= '0;
    end else if (w_fire && (r_state == S_DROP)) begin
      r_drop <= (&r_drop) ? r_drop : r_drop + 16'd1;
    end
  end

  // ---------------------------------------------------------------------------
  // Status counters and flags. On a clear cycle, this cycle's updates are
  // dropped.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (!reset || clear) begin
      pkt_count  <= '0;
      good_count <= '0;
      err_count  <= '0;
      err_code   <= '0;
      last_len   <= '0;
    end else begin
      if (w_err_evt) begin
        err_count <= sat_inc(err_count);
      end
      err_code <= err_code | {w_over, w_mismatch, w_restart, w_orphan};
      if (w_close_pkt) begin
        pkt_count <= sat_inc(pkt_count);
        last_len  <= w_idx_nxt[15:0];
        if (!w_bad_nxt) begin
          good_count <= sat_inc(good_count);
        end
      end else if (w_close_drop) begin
        pkt_count <= sat_inc(pkt_count);
        last_len  <= w_drop_len;
      end
    end
  end

endmodule
